// File: rtl/aq_fadd_pkg.sv
// Shared encodings for the vector FADD unit: operand formats and the
// sign/exponent/fraction bit positions of each packed IEEE format.
package aq_fadd_pkg;

    typedef enum logic [1:0] {
        FMT_D  = 2'b00,
        FMT_S  = 2'b01,
        FMT_H  = 2'b10,
        FMT_BH = 2'b11
    } fadd_fmt_e;

    // Fraction always starts at bit 0; the exponent sits directly above it.
    localparam int D_SIGN    = 63;
    localparam int D_EXP_LSB = 52;
    localparam int D_EXP_W   = 11;
    localparam int D_FRAC_W  = 52;

    localparam int S_SIGN    = 31;
    localparam int S_EXP_LSB = 23;
    localparam int S_EXP_W   = 8;
    localparam int S_FRAC_W  = 23;

    localparam int H_SIGN    = 15;
    localparam int H_EXP_LSB = 10;
    localparam int H_EXP_W   = 5;
    localparam int H_FRAC_W  = 10;

    localparam int BH_SIGN    = 15;
    localparam int BH_EXP_LSB = 7;
    localparam int BH_EXP_W   = 8;
    localparam int BH_FRAC_W  = 7;

endpackage

// File: rtl/aq_fadd_rslt_lane.sv
// Single-lane EX2 result merge: picks special, min/max select or add/sub
// result and widens the fields to the common EXP_W/FRAC_W layout.
module aq_fadd_rslt_lane
    import aq_fadd_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 54
) (
    input  logic [1:0]        fmt,
    input  logic              lane_en,
    input  logic              op_sel,
    input  logic              special_vld,
    input  logic [63:0]       special_data,
    input  logic              sel_sign,
    input  logic [EXP_W-1:0]  sel_e,
    input  logic [FRAC_W-3:0] sel_f,
    input  logic              add_sign,
    input  logic [EXP_W-1:0]  add_e,
    input  logic [FRAC_W-1:0] add_f,
    input  logic              nv,
    output logic              rslt_sign,
    output logic [EXP_W-1:0]  rslt_e,
    output logic [FRAC_W-1:0] rslt_f,
    output logic              rslt_nv,
    output logic              rslt_special_n_sel
);

    logic              sp_sign;
    logic [EXP_W-1:0]  sp_e;
    logic [FRAC_W-1:0] sp_f;

    always_comb begin
        sp_sign = 1'b0;
        sp_e    = '0;
        sp_f    = '0;
        case (fadd_fmt_e'(fmt))
            FMT_D: begin
                sp_sign = special_data[D_SIGN];
                sp_e    = EXP_W'(special_data[D_EXP_LSB +: D_EXP_W]);
                sp_f    = FRAC_W'(special_data[D_FRAC_W-1:0]);
            end
            FMT_S: begin
                sp_sign = special_data[S_SIGN];
                sp_e    = EXP_W'(special_data[S_EXP_LSB +: S_EXP_W]);
                sp_f    = FRAC_W'(special_data[S_FRAC_W-1:0]);
            end
            FMT_H: begin
                sp_sign = special_data[H_SIGN];
                sp_e    = EXP_W'(special_data[H_EXP_LSB +: H_EXP_W]);
                sp_f    = FRAC_W'(special_data[H_FRAC_W-1:0]);
            end
            FMT_BH: begin
                sp_sign = special_data[BH_SIGN];
                sp_e    = EXP_W'(special_data[BH_EXP_LSB +: BH_EXP_W]);
                sp_f    = FRAC_W'(special_data[BH_FRAC_W-1:0]);
            end
        endcase
    end

    // Disabled lanes store all-zero fields so downstream never sees stale data.
    always_comb begin
        rslt_sign          = 1'b0;
        rslt_e             = '0;
        rslt_f             = '0;
        rslt_nv            = 1'b0;
        rslt_special_n_sel = 1'b0;
        if (lane_en) begin
            rslt_nv            = nv;
            rslt_special_n_sel = special_vld | op_sel;
            if (special_vld) begin
                rslt_sign = sp_sign;
                rslt_e    = sp_e;
                rslt_f    = sp_f;
            end else if (op_sel) begin
                rslt_sign = sel_sign;
                rslt_e    = sel_e;
                rslt_f    = {2'b00, sel_f};
            end else begin
                rslt_sign = add_sign;
                rslt_e    = add_e;
                rslt_f    = add_f;
            end
        end
    end

endmodule

// File: rtl/aq_fadd_rslt_pipe.sv
// Multi-lane EX2->EX3 result merge with a small output FIFO, valid/ready
// handshake, flush and a sticky invalid-operation flag.
module aq_fadd_rslt_pipe
    import aq_fadd_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int FRAC_W = 54,
    parameter int EXP_W  = 11,
    parameter int DEPTH  = 2
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      ex2_vld,
    output logic                      ex2_rdy,
    input  logic [1:0]                ex2_fmt,
    input  logic                      ex2_op_sel,
    input  logic                      ex2_op_cmp,
    input  logic [LANES-1:0]          ex2_lane_en,
    input  logic [LANES-1:0]          ex2_special_vld,
    input  logic [LANES*64-1:0]       ex2_special_data,
    input  logic [LANES-1:0]          ex2_sel_sign,
    input  logic [LANES*EXP_W-1:0]    ex2_sel_e,
    input  logic [LANES*(FRAC_W-2)-1:0] ex2_sel_f,
    input  logic [LANES-1:0]          ex2_add_sign,
    input  logic [LANES*EXP_W-1:0]    ex2_add_e,
    input  logic [LANES*FRAC_W-1:0]   ex2_add_f,
    input  logic [LANES-1:0]          ex2_nv,
    output logic                      ex3_vld,
    input  logic                      ex3_rdy,
    output logic [LANES-1:0]          ex3_sign,
    output logic [LANES*EXP_W-1:0]    ex3_e,
    output logic [LANES*FRAC_W-1:0]   ex3_f,
    output logic [LANES-1:0]          ex3_nv,
    output logic                      ex3_nocmp_nosel,
    output logic [LANES-1:0]          ex3_special_n_sel,
    input  logic                      flush,
    input  logic                      nv_clr,
    output logic                      nv_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int O_E   = LANES;
    localparam int O_F   = O_E + LANES*EXP_W;
    localparam int O_NV  = O_F + LANES*FRAC_W;
    localparam int O_SN  = O_NV + LANES;
    localparam int O_NC  = O_SN + LANES;
    localparam int ENT_W = O_NC + 1;

    logic [LANES-1:0]        sign_p0;
    logic [LANES*EXP_W-1:0]  e_p0;
    logic [LANES*FRAC_W-1:0] f_p0;
    logic [LANES-1:0]        nv_p0;
    logic [LANES-1:0]        sn_p0;
    logic [ENT_W-1:0]        entry_p0;

    // ---- stage p0: per-lane merge of the EX2 results ----
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aq_fadd_rslt_lane #(
            .EXP_W  (EXP_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .fmt                (ex2_fmt),
            .lane_en            (ex2_lane_en[l]),
            .op_sel             (ex2_op_sel),
            .special_vld        (ex2_special_vld[l]),
            .special_data       (ex2_special_data[l*64 +: 64]),
            .sel_sign           (ex2_sel_sign[l]),
            .sel_e              (ex2_sel_e[l*EXP_W +: EXP_W]),
            .sel_f              (ex2_sel_f[l*(FRAC_W-2) +: FRAC_W-2]),
            .add_sign           (ex2_add_sign[l]),
            .add_e              (ex2_add_e[l*EXP_W +: EXP_W]),
            .add_f              (ex2_add_f[l*FRAC_W +: FRAC_W]),
            .nv                 (ex2_nv[l]),
            .rslt_sign          (sign_p0[l]),
            .rslt_e             (e_p0[l*EXP_W +: EXP_W]),
            .rslt_f             (f_p0[l*FRAC_W +: FRAC_W]),
            .rslt_nv            (nv_p0[l]),
            .rslt_special_n_sel (sn_p0[l])
        );
    end

    assign entry_p0 = {~ex2_op_cmp & ~ex2_op_sel, sn_p0, nv_p0, f_p0, e_p0, sign_p0};

    // ---- stage p1: FIFO storage and handshake ----
    logic [ENT_W-1:0] mem_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] cnt_nxt;
    logic             vld_p1;
    logic             rdy_p1;
    logic             sticky_p1;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head_p1;

    assign push = ex2_vld & rdy_p1 & ~flush;
    assign pop  = vld_p1 & ex3_rdy;

    always_comb begin
        cnt_nxt = cnt_p1;
        if (flush)
            cnt_nxt = '0;
        else if (push && !pop)
            cnt_nxt = cnt_p1 + CNT_W'(1);
        else if (pop && !push)
            cnt_nxt = cnt_p1 - CNT_W'(1);
    end

    // Storage is data-only; its contents are masked by vld_p1 on the way out.
    always_ff @(posedge forever_cpuclk) begin
        if (push)
            mem_p1[wr_ptr_p1] <= entry_p0;
    end

    // rdy/vld are registered from the next count, so ex3_rdy never reaches ex2_rdy.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            cnt_p1    <= '0;
            vld_p1    <= 1'b0;
            rdy_p1    <= 1'b1;
            sticky_p1 <= 1'b0;
        end else begin
            cnt_p1    <= cnt_nxt;
            vld_p1    <= (cnt_nxt != '0);
            rdy_p1    <= (cnt_nxt < CNT_W'(DEPTH));
            sticky_p1 <= (nv_clr ? 1'b0 : sticky_p1) | (pop & (|ex3_nv));
            if (flush) begin
                wr_ptr_p1 <= '0;
                rd_ptr_p1 <= '0;
            end else begin
                if (push)
                    wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
                if (pop)
                    rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            end
        end
    end

    assign head_p1 = vld_p1 ? mem_p1[rd_ptr_p1] : '0;

    assign ex2_rdy           = rdy_p1;
    assign ex3_vld           = vld_p1;
    assign nv_sticky         = sticky_p1;
    assign ex3_sign          = head_p1[LANES-1:0];
    assign ex3_e             = head_p1[O_E +: LANES*EXP_W];
    assign ex3_f             = head_p1[O_F +: LANES*FRAC_W];
    assign ex3_nv            = head_p1[O_NV +: LANES];
    assign ex3_special_n_sel = head_p1[O_SN +: LANES];
    assign ex3_nocmp_nosel   = head_p1[O_NC];

endmodule
